// File: rtl/dds_pkg.sv
// dds_pkg: shared constants and types for the DDS generator and its
// receive-side frequency meter.
//   K_W    : tuning word / phase accumulator width
//   DATA_W : waveform sample width (unsigned offset binary)
//   N_LOG2 : log2 of the number of periods averaged by the meter
//   MID    : mid-scale sample value for DATA_W
//   state_t: frequency meter control states
package dds_pkg;

  localparam int K_W    = 32;
  localparam int DATA_W = 10;
  localparam int N_LOG2 = 3;
  localparam int MID    = 1 << (DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    MEAS,
    DIV,
    DONE
  } state_t;

endpackage

// File: rtl/dds_serial_div.sv
// dds_serial_div: unsigned restoring divider, one quotient bit per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : 1-cycle pulse, latches dividend/divisor and computes the
//                first quotient bit in the same cycle (restarts if busy)
//   dividend   : DVD_W-bit dividend
//   divisor    : DVS_W-bit divisor (must be non-zero)
//   busy       : remaining quotient bits are being computed
//   done       : 1-cycle pulse, quotient valid from this cycle on
//   quotient   : DVD_W-bit quotient, held until the next start
// A division takes DVD_W clock edges: done is high DVD_W cycles after start.
module dds_serial_div #(
  parameter int DVD_W = 36,
  parameter int DVS_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient
);

  localparam int                  CNT_BITS = $clog2(DVD_W + 1);
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(DVD_W - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

  logic [DVS_W-1:0]    rem_q;
  logic [DVS_W-1:0]    dvs_q;
  logic [DVD_W-1:0]    dvd_q;
  logic [DVD_W-1:0]    quo_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic                done_q;

  logic [DVS_W-1:0]    step_rem;
  logic [DVS_W-1:0]    step_dvs;
  logic                step_bit;
  logic [DVS_W:0]      step_res;

  // One restoring step: returns {quotient bit, new remainder}. The partial
  // remainder is always below the divisor, so the difference fits DVS_W bits.
  function automatic logic [DVS_W:0] div_step(input logic [DVS_W-1:0] rem,
                                               input logic             bit_in,
                                               input logic [DVS_W-1:0] dvs);
    logic [DVS_W:0]   trial;
    logic [DVS_W-1:0] diff;
    trial = {rem, bit_in};
    diff  = trial[DVS_W-1:0] - dvs;
    if (trial >= {1'b0, dvs}) div_step = {1'b1, diff};
    else                      div_step = {1'b0, trial[DVS_W-1:0]};
  endfunction

  // The start cycle already performs the first step on a zero remainder.
  always_comb begin
    step_rem = start ? '0 : rem_q;
    step_bit = start ? dividend[DVD_W-1] : dvd_q[DVD_W-1];
    step_dvs = start ? divisor : dvs_q;
    step_res = div_step(step_rem, step_bit, step_dvs);
  end

  always_ff @(posedge clk) begin
    if (start) begin
      dvs_q <= divisor;
      dvd_q <= {dividend[DVD_W-2:0], 1'b0};
      rem_q <= step_res[DVS_W-1:0];
      quo_q <= {{(DVD_W-1){1'b0}}, step_res[DVS_W]};
    end else if (cnt_q != '0) begin
      dvd_q <= {dvd_q[DVD_W-2:0], 1'b0};
      rem_q <= step_res[DVS_W-1:0];
      quo_q <= {quo_q[DVD_W-2:0], step_res[DVS_W]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        cnt_q <= CNT_INIT;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CNT_ONE) done_q <= 1'b1;
      end
    end
  end

  assign busy     = (cnt_q != '0);
  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/dds_freq_meter.sv
// dds_freq_meter: measures the frequency of a sampled periodic waveform and
// reports it as the equivalent DDS tuning word
//   K_est = 2^(K_W+N_LOG2) / (valid samples in 2^N_LOG2 periods).
//   clk, rst_n : clock, asynchronous active-low reset
//   wave_in    : DATA_W-bit unsigned offset-binary sample
//   wave_vld   : wave_in valid this cycle
//   start      : 1-cycle pulse, begins a measurement (only accepted when idle)
//   busy       : measurement in progress
//   done       : 1-cycle pulse, results below updated this cycle
//   timeout    : last measurement aborted because no rise arrived in time
//   period_sum : valid samples counted over the averaged periods
//   K_est      : estimated tuning word (0 after a timeout)
module dds_freq_meter
  import dds_pkg::*;
#(
  parameter int DATA_W  = 10,
  parameter int K_W     = 32,
  parameter int N_LOG2  = 3,
  parameter int HYST    = 16,
  parameter int CNT_W   = 32,
  parameter int TMO_CYC = 1048576
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] wave_in,
  input  logic              wave_vld,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  period_sum,
  output logic [K_W-1:0]    K_est
);

  localparam int                 Q_W      = K_W + N_LOG2 + 1;
  localparam int                 MID_V    = 1 << (DATA_W - 1);
  localparam logic [DATA_W-1:0]  HI_TH    = DATA_W'(MID_V + HYST);
  localparam logic [DATA_W-1:0]  LO_TH    = DATA_W'(MID_V - HYST);
  localparam logic [N_LOG2-1:0]  PER_LAST = '1;
  localparam int                 GAP_W    = $clog2(TMO_CYC + 1);
  localparam logic [GAP_W-1:0]   TMO_LAST = GAP_W'(TMO_CYC - 1);
  localparam logic [Q_W-1:0]     DIVIDEND = {1'b1, {(Q_W-1){1'b0}}};

  if ((longint'(TMO_CYC) << N_LOG2) >= (longint'(1) << CNT_W)) begin : g_sum_range
    $error("dds_freq_meter: TMO_CYC * 2**N_LOG2 must stay below 2**CNT_W");
  end

  state_t            state_q, state_d;
  logic              hi_q;
  logic              rise, fall;
  logic [CNT_W-1:0]  sum_q;
  logic [N_LOG2-1:0] per_q;
  logic [GAP_W-1:0]  gap_q;
  logic              div_start, div_busy, div_done, tmo_hit;
  logic [Q_W-1:0]    div_quo;

  function automatic logic [K_W-1:0] sat_k(input logic [Q_W-1:0] q);
    if (|q[Q_W-1:K_W]) sat_k = '1;
    else               sat_k = q[K_W-1:0];
  endfunction

  // Schmitt-trigger crossing detector; runs regardless of FSM state.
  assign rise = wave_vld && !hi_q && (wave_in >= HI_TH);
  assign fall = wave_vld &&  hi_q && (wave_in <  LO_TH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    hi_q <= 1'b1;
    else if (rise) hi_q <= 1'b1;
    else if (fall) hi_q <= 1'b0;
  end

  // gap_q counts cycles since the last start/rise, the clearing edge counting
  // as the first; the output register adds the final cycle of the timeout.
  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    tmo_hit   = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = SYNC;
      SYNC: begin
        if (rise) begin
          state_d = MEAS;
        end else if (gap_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_d = DONE;
        end
      end
      MEAS: begin
        if (rise && per_q == PER_LAST && !div_busy) begin
          div_start = 1'b1;
          state_d   = DIV;
        end else if (!rise && gap_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_d = DONE;
        end
      end
      DIV:  if (div_done) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      per_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == SYNC)              per_q <= '0;
      else if (state_q == MEAS && rise) per_q <= per_q + 1'b1;
      if ((state_q == IDLE && start) || rise)    gap_q <= GAP_W'(1);
      else if (state_q == SYNC || state_q == MEAS) gap_q <= gap_q + 1'b1;
    end
  end

  // Sample counter: the N-th rise sample itself is counted, the sync rise is not.
  always_ff @(posedge clk) begin
    if (state_q == SYNC)                  sum_q <= '0;
    else if (state_q == MEAS && wave_vld) sum_q <= sum_q + 1'b1;
  end

  // Divisor includes the final rise sample, whose count lands in sum_q
  // on the same edge the divider starts.
  dds_serial_div #(
    .DVD_W (Q_W),
    .DVS_W (CNT_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (DIVIDEND),
    .divisor  (sum_q + 1'b1),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      period_sum <= '0;
      K_est      <= '0;
    end else begin
      busy <= (state_d == SYNC) || (state_d == MEAS) || (state_d == DIV);
      done <= (state_d == DONE) && (state_q != DONE);
      if (state_d == DONE && state_q != DONE) begin
        timeout    <= tmo_hit;
        period_sum <= sum_q;
        K_est      <= tmo_hit ? '0 : sat_k(div_quo);
      end
    end
  end

endmodule

// File: tb/tb_dds_freq_meter.sv
// tb_dds_freq_meter: scoreboard bench for dds_freq_meter. A sine DDS model
// drives wave_in; expected results are queued at each start and compared when
// done pulses. A behavioural Schmitt model timestamps the final rise for the
// latency check.
module tb_dds_freq_meter;

  localparam int DATA_W  = 10;
  localparam int K_W     = 32;
  localparam int N_LOG2  = 3;
  localparam int HYST    = 16;
  localparam int CNT_W   = 32;
  localparam int TMO_CYC = 3000;
  localparam int N       = 1 << N_LOG2;
  localparam int Q_W     = K_W + N_LOG2 + 1;
  localparam int HI_TH   = 512 + HYST;
  localparam int LO_TH   = 512 - HYST;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [DATA_W-1:0] wave_in = '0;
  logic              wave_vld = 1'b1;
  logic              start = 1'b0;
  logic              busy, done, timeout;
  logic [CNT_W-1:0]  period_sum;
  logic [K_W-1:0]    K_est;

  dds_freq_meter #(
    .DATA_W  (DATA_W),
    .K_W     (K_W),
    .N_LOG2  (N_LOG2),
    .HYST    (HYST),
    .CNT_W   (CNT_W),
    .TMO_CYC (TMO_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wave_in    (wave_in),
    .wave_vld   (wave_vld),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .period_sum (period_sum),
    .K_est      (K_est)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [CNT_W-1:0] ps;
    logic [K_W-1:0]   k;
    logic             tmo;
    bit               approx;
    bit               from_start;
    logic [31:0]      kref;
  } exp_t;

  exp_t  sb[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc = 0;
  string tname = "reset";

  // DDS / detector model state
  logic [31:0] acc = '0;
  logic [31:0] kdds = '0;
  bit          noise_en = 0;
  bit          hold_mid = 0;
  bit          model_hi = 1;
  bit          armed = 0;
  int          start_cyc = 0;
  int          nrise = 0;
  int          final_cyc = 0;
  int          rom[1024];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t exact(input int t);
    exp_t   e;
    longint q;
    q = (longint'(1) << (K_W + N_LOG2)) / longint'(N * t);
    e.ps = CNT_W'(N * t);
    e.k = (q >= (longint'(1) << K_W)) ? '1 : K_W'(q);
    e.tmo = 1'b0;
    e.approx = 0;
    e.from_start = 0;
    e.kref = '0;
    return e;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Waveform generator, 2 time units after each edge.
  initial begin
    int w;
    for (int i = 0; i < 1024; i++)
      rom[i] = $rtoi(511.0 * $sin(2.0 * 3.14159265358979 * i / 1024.0) + 512.5);
    forever begin
      @(posedge clk);
      #2;
      if (hold_mid) begin
        w = 512;
      end else begin
        w = rom[acc[31:22]];
        if (noise_en) w = w + int'($urandom_range(16)) - 8;
        if (w < 0) w = 0;
        if (w > 1023) w = 1023;
        acc = acc + kdds;
      end
      wave_in = w[DATA_W-1:0];
      if (!rst_n) begin
        model_hi = 1;
      end else if (!model_hi && w >= HI_TH) begin
        model_hi = 1;
        if (armed && cyc > start_cyc) begin
          nrise++;
          if (nrise == N + 1) final_cyc = cyc;
        end
      end else if (model_hi && w < LO_TH) begin
        model_hi = 0;
      end
    end
  end

  // Scoreboard monitor on the falling edge.
  initial begin
    exp_t e;
    real  ref_ps, dps, dk;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) begin
          chk({tname, ".unexpected_done"}, 1, 0);
        end else begin
          e = sb.pop_front();
          if (e.approx) begin
            ref_ps = 8.0 * 4294967296.0 / real'(e.kref);
            dps = real'(period_sum) - ref_ps;
            dk = real'(K_est) - real'(e.kref);
            if (dk < 0.0) dk = -dk;
            chk({tname, ".period_sum_within_1"}, (dps <= 1.0 && dps >= -1.0), 1);
            chk({tname, ".K_est_within_0p06pct"}, (dk <= 0.0006 * real'(e.kref)), 1);
          end else begin
            chk({tname, ".period_sum"}, period_sum, e.ps);
            chk({tname, ".K_est"}, K_est, e.k);
          end
          chk({tname, ".timeout"}, timeout, e.tmo);
          chk({tname, ".busy_at_done"}, busy, 0);
          if (e.from_start) chk({tname, ".latency_from_start"}, cyc - start_cyc, TMO_CYC);
          else              chk({tname, ".latency_from_rise"}, cyc - final_cyc, Q_W + 1);
          @(negedge clk);
          chk({tname, ".done_one_cycle"}, done, 0);
        end
      end
    end
  end

  task automatic set_dds(input logic [31:0] k, input bit nz, input bit hold);
    @(posedge clk);
    #1;
    kdds = k;
    acc = '0;
    noise_en = nz;
    hold_mid = hold;
    repeat (4) @(posedge clk);
  endtask

  task automatic run_meas(input string name, input exp_t e, input int budget, input int extra_starts);
    int n;
    @(posedge clk);
    #1;
    tname = name;
    armed = 1;
    nrise = 0;
    final_cyc = -100000;
    start_cyc = cyc;
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({name, ".busy_after_start"}, busy, 1);
    for (int i = 0; i < extra_starts; i++) begin
      repeat (20) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk({name, ".done_within_budget"}, 0, 1);
      sb.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    exp_t e;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.timeout", timeout, 0);
    chk("reset.period_sum", period_sum, 0);
    chk("reset.K_est", K_est, 0);
    rst_n = 1'b1;

    set_dds(32'h0400_0000, 0, 0);
    run_meas("t1_T64", exact(64), 4000, 0);

    set_dds(32'h2000_0000, 0, 0);
    run_meas("t2_T8", exact(8), 4000, 0);

    set_dds(32'h0123_4567, 0, 0);
    e = exact(225);
    e.approx = 1;
    e.kref = 32'h0123_4567;
    run_meas("t3_K01234567", e, 4000, 0);

    set_dds(32'h0400_0000, 1, 0);
    run_meas("t4_noisy_T64", exact(64), 4000, 0);

    // Abort mid-measurement with reset; nothing is queued, so any done is flagged.
    set_dds(32'h0400_0000, 0, 0);
    tname = "t6_abort";
    @(posedge clk);
    #1;
    armed = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    chk("t6_abort.busy_mid_meas", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_abort.busy", busy, 0);
    chk("t6_abort.done", done, 0);
    chk("t6_abort.timeout", timeout, 0);
    chk("t6_abort.period_sum", period_sum, 0);
    chk("t6_abort.K_est", K_est, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_abort.idle_after_reset", busy, 0);
    run_meas("t6_fresh_T64", exact(64), 4000, 3);

    set_dds(32'h0, 0, 1);
    e = exact(64);
    e.ps = '0;
    e.k = '0;
    e.tmo = 1'b1;
    e.from_start = 1;
    run_meas("t5_timeout", e, TMO_CYC + 200, 0);

    set_dds(32'h0400_0000, 0, 0);
    run_meas("t1_after_timeout", exact(64), 4000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, %0d cycles elapsed, limit 60000", cyc);
    $fatal(1, "watchdog");
  end

endmodule
